// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU: widths, loader states,
// and control-word bit positions used by the memory stage.
package cpu_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  localparam int CTL_MAR_LOAD = 0;
  localparam int CTL_RAM_OE   = 1;
  localparam int CTL_RAM_WE   = 2;
  localparam int CTL_W        = 3;

endpackage

// File: rtl/memory_unit_if.sv
// Bus, control and loader signals of the memory stage.
// slave: memory_unit side; master: CPU bus/control/loader side.
interface memory_unit_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic [DATA_W-1:0] bus_in;
  logic [DATA_W-1:0] bus_out;
  logic              bus_oe;
  logic              mar_load;
  logic              ram_oe;
  logic              ram_we;
  logic              prog_mode;
  logic [DATA_W-1:0] prog_data;
  logic              prog_valid;
  logic              prog_ready;
  logic              prog_done;
  logic [ADDR_W-1:0] mar_q;

  modport slave (
    input  bus_in, mar_load, ram_oe, ram_we,
    input  prog_mode, prog_data, prog_valid,
    output bus_out, bus_oe, prog_ready,
    output prog_done, mar_q
  );

  modport master (
    output bus_in, mar_load, ram_oe, ram_we,
    output prog_mode, prog_data, prog_valid,
    input  bus_out, bus_oe, prog_ready,
    input  prog_done, mar_q
  );

endinterface

// File: rtl/memory_unit_ram_array.sv
// ram_array: 2**ADDR_W x DATA_W flop RAM, cleared by async reset.
// Ports: clk, rst, we/waddr/wdata (sync write), raddr/rdata (comb read).
module ram_array
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/memory_unit.sv
// Memory stage: MAR, byte-serial program loader FSM, 16x8 RAM.
// Ports: clk, rst, io (memory_unit_if.slave). Macro MEM_BUS_WRITE_EN
// enables bus stores (ram_we) in run mode.
module memory_unit
  import cpu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  memory_unit_if.slave  io
);

  localparam logic [ADDR_W-1:0] LAST = '1;

  ld_state_e         state;
  ld_state_e         nstate;
  logic [ADDR_W-1:0] count;
  logic [ADDR_W-1:0] mar;
  logic [CTL_W-1:0]  ctl;
  logic              idle;
  logic              xfer;

  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    ctl               = '0;
    ctl[CTL_MAR_LOAD] = io.mar_load;
    ctl[CTL_RAM_OE]   = io.ram_oe;
    ctl[CTL_RAM_WE]   = io.ram_we;
  end

  assign idle = (state == IDLE);
  assign xfer = (state == LOAD) && io.prog_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE: if (io.prog_mode) nstate = LOAD;
      LOAD: begin
        if (!io.prog_mode) begin
          nstate = IDLE;
        end else if (io.prog_valid && count == LAST) begin
          nstate = DONE;
        end
      end
      DONE: if (!io.prog_mode) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Count holds at LAST on the final byte so it never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (state != LOAD || !io.prog_mode) begin
      count <= '0;
    end else if (io.prog_valid && count != LAST) begin
      count <= count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mar <= '0;
    end else if (idle && ctl[CTL_MAR_LOAD]) begin
      mar <= io.bus_in[ADDR_W-1:0];
    end
  end

  // Loader owns the write port outside run mode; a bus store
  // uses the pre-edge MAR even if mar_load fires too.
  always_comb begin
    we    = 1'b0;
    waddr = '0;
    wdata = '0;
    if (xfer) begin
      we    = 1'b1;
      waddr = count;
      wdata = io.prog_data;
    end
`ifdef MEM_BUS_WRITE_EN
    else if (idle && ctl[CTL_RAM_WE]) begin
      we    = 1'b1;
      waddr = mar;
      wdata = io.bus_in;
    end
`endif
  end

  ram_array #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(mar),
    .rdata(rdata)
  );

  assign io.bus_out    = idle ? rdata : '0;
  assign io.bus_oe     = idle && ctl[CTL_RAM_OE];
  assign io.prog_ready = (state == LOAD);
  assign io.prog_done  = (state == DONE);
  assign io.mar_q      = mar;

  logic unused_bits;
  assign unused_bits = ^{io.bus_in[DATA_W-1:ADDR_W],
                         ctl[CTL_RAM_WE]};

endmodule
